// File: rtl/dungv_pkg.sv
// Shared fetch-stage types and defaults: instruction width, PC width, reset PC and FIFO payload.
package dungv_pkg;

   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned PC_W     = 10;
   localparam int unsigned RESET_PC = 0;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between instruction memory and decode.
// Synchronous FIFO with push, pop and flush; flush empties it and wins over push/pop.
module fetch_fifo
   import dungv_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     wdata,
   output fetch_entry_t     rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Storage, pointers and occupancy; storage is cleared on reset so the head reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one-at-a-time word reads to instruction memory,
// buffers responses in fetch_fifo and presents {instruction, pc} to decode.
// Optional build macro INSTR_FETCH_PERF_EN adds a saturating decode-stall counter (stall_cnt).
module instr_fetch
   import dungv_pkg::*;
#(
   parameter int unsigned PC_W     = dungv_pkg::PC_W,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned RESET_PC = dungv_pkg::RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instruction,
   output logic [PC_W-1:0] instr_pc,
   input  logic            redir_valid,
`ifdef INSTR_FETCH_PERF_EN
   output logic [31:0]     stall_cnt,
`endif
   input  logic [PC_W-1:0] redir_pc
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned EPC_W = $bits(fetch_entry_t) - INSTR_W;

   // WAIT means exactly one granted request awaits its rvalid.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT
   } state_t;

   state_t           state;
   logic [PC_W-1:0]  pc;
   logic             drop;
   logic             granted_c;
   logic             push_c;
   logic             pop_c;
   logic             credit_c;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next_c;
   fetch_entry_t     push_entry_c;
   fetch_entry_t     head;

   assign granted_c    = imem_req & imem_gnt;
   assign push_c       = (state == ST_WAIT) & imem_rvalid & ~drop & ~redir_valid
                         & (~fifo_full | pop_c);
   assign pop_c        = instr_valid & instr_ready & ~redir_valid;
   assign push_entry_c = '{instr: imem_rdata, pc: EPC_W'(imem_addr)};

   // Occupancy after this cycle; a new request is launched only if its word will fit.
   always_comb begin
      count_next_c = count;
      if (redir_valid) begin
         count_next_c = '0;
      end else begin
         count_next_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
      end
   end

   assign credit_c = (count_next_c < CNT_W'(DEPTH));

   // Request FSM, PC and stale-response drop flag; redirect overrides everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         pc        <= PC_W'(RESET_PC);
         imem_req  <= 1'b0;
         imem_addr <= '0;
         drop      <= 1'b0;
      end else if (redir_valid) begin
         pc        <= redir_pc;
         imem_addr <= redir_pc;
         if (granted_c || (state == ST_WAIT && !imem_rvalid)) begin
            drop     <= 1'b1;
            imem_req <= 1'b0;
            state    <= ST_WAIT;
         end else begin
            drop     <= 1'b0;
            imem_req <= 1'b1;
            state    <= ST_REQ;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (credit_c) begin
                  state     <= ST_REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
               end
            end
            ST_REQ: begin
               if (imem_gnt) begin
                  pc       <= pc + PC_W'(1);
                  imem_req <= 1'b0;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  drop <= 1'b0;
                  if (credit_c) begin
                     state     <= ST_REQ;
                     imem_req  <= 1'b1;
                     imem_addr <= pc;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c),
      .pop   (pop_c),
      .flush (redir_valid),
      .wdata (push_entry_c),
      .rdata (head),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign instr_valid = ~fifo_empty;
   assign instruction = head.instr;
   assign instr_pc    = PC_W'(head.pc);

`ifdef INSTR_FETCH_PERF_EN
   // Saturating count of cycles where decode is ready but fetch has nothing to offer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (instr_ready && !instr_valid && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
